// File: rtl/weight_pattern_gen.sv
// Enumerates every 6-bit word of Hamming weight k in ascending order, one per handshake.
// Optional macro WPG_COUNT_EN adds the pattern_idx ordinal output.
module weight_pattern_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] weight,
  input  logic       out_ready,
  output logic [5:0] pattern,
  output logic       pattern_valid,
  output logic       last,
  output logic       busy,
  output logic       done,
`ifdef WPG_COUNT_EN
  output logic [4:0] pattern_idx,
`endif
  output logic       err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [5:0] pattern_q, pattern_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
`ifdef WPG_COUNT_EN
  logic [4:0] idx_q, idx_d;
`endif

  logic [5:0] succ_word;

  function automatic logic [5:0] lowest_word(input logic [2:0] k);
    return ~(6'h3f << k);
  endfunction

  function automatic logic [5:0] highest_word(input logic [2:0] k);
    return lowest_word(k) << (3'd6 - k);
  endfunction

  // Gosper's hack; the lowest set bit is a power of two, so the divide is a shift.
  function automatic logic [5:0] next_word(input logic [5:0] x);
    logic [5:0] low_bit;
    logic [5:0] ripple;
    logic [2:0] tz;
    low_bit = x & (~x + 6'd1);
    ripple  = x + low_bit;
    tz      = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (low_bit[i]) tz = 3'(i);
    end
    return ripple | (((ripple ^ x) >> 2) >> tz);
  endfunction

  assign succ_word = next_word(pattern_q);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pattern_d = pattern_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef WPG_COUNT_EN
    idx_d     = idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (weight == 3'd7) begin
            err_d = 1'b1;
          end else begin
            state_d   = RUN;
            k_d       = weight;
            pattern_d = lowest_word(weight);
            valid_d   = 1'b1;
            last_d    = (lowest_word(weight) == highest_word(weight));
            busy_d    = 1'b1;
`ifdef WPG_COUNT_EN
            idx_d     = 5'd0;
`endif
          end
        end
      end
      RUN: begin
        if (valid_q && out_ready) begin
          if (last_q) begin
            state_d   = IDLE;
            pattern_d = 6'd0;
            valid_d   = 1'b0;
            last_d    = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
`ifdef WPG_COUNT_EN
            idx_d     = 5'd0;
`endif
          end else begin
            pattern_d = succ_word;
            last_d    = (succ_word == highest_word(k_q));
`ifdef WPG_COUNT_EN
            idx_d     = idx_q + 5'd1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= 3'd0;
      pattern_q <= 6'd0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef WPG_COUNT_EN
      idx_q     <= 5'd0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pattern_q <= pattern_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef WPG_COUNT_EN
      idx_q     <= idx_d;
`endif
    end
  end

  assign pattern       = pattern_q;
  assign pattern_valid = valid_q;
  assign last          = last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
`ifdef WPG_COUNT_EN
  assign pattern_idx   = idx_q;
`endif

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Scoreboard bench for weight_pattern_gen: a popcount-filtered model queue is compared per handshake.
module tb_weight_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] weight;
  logic       out_ready;
  logic [5:0] pattern;
  logic       pattern_valid;
  logic       last;
  logic       busy;
  logic       done;
  logic       err;
`ifdef WPG_COUNT_EN
  logic [4:0] pattern_idx;
`endif

  always #5 clk = ~clk;

  weight_pattern_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .weight       (weight),
    .out_ready    (out_ready),
    .pattern      (pattern),
    .pattern_valid(pattern_valid),
    .last         (last),
    .busy         (busy),
    .done         (done),
`ifdef WPG_COUNT_EN
    .pattern_idx  (pattern_idx),
`endif
    .err          (err)
  );

  typedef struct {
    logic [5:0] pat;
    logic       lst;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt    = 0;
  int   miscmp_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_cnt++;
    if (obs !== expv) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected words come from filtering 0..63 by popcount, highest one flagged last.
  task automatic load_model(input int k);
    exp_t e;
    exp_q.delete();
    for (int v = 0; v < 64; v++) begin
      if ($countones(6'(v)) == k) begin
        e.pat = 6'(v);
        e.lst = 1'b0;
        exp_q.push_back(e);
      end
    end
    exp_q[exp_q.size()-1].lst = 1'b1;
  endtask

  task automatic check_handshake(input int k, input int hs);
    exp_t e;
    e = exp_q.pop_front();
    $display("k=%0d word %0d: pattern=%02h last=%b (exp %02h/%b)", k, hs, pattern, last, e.pat, e.lst);
    check_eq("pattern", 32'(pattern), 32'(e.pat));
    check_eq("last", 32'(last), 32'(e.lst));
`ifdef WPG_COUNT_EN
    check_eq("pattern_idx", 32'(pattern_idx), 32'(hs));
`endif
  endtask

  task automatic run_seq(input int k, input bit rnd, input bit inject);
    int         hs;
    bit         stalled;
    bit         fin;
    logic [5:0] held_pat;
    logic       held_last;
    hs       = 0;
    stalled  = 1'b0;
    fin      = 1'b0;
    held_pat = 6'd0;
    held_last = 1'b0;
    load_model(k);
    start  = 1'b1;
    weight = 3'(k);
    tick();
    start = 1'b0;
    check_eq("first_valid", 32'(pattern_valid), 32'd1);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && cyc == 3) begin
        start  = 1'b1;
        weight = 3'd5;
      end
      if (stalled) begin
        check_eq("hold_pattern", 32'(pattern), 32'(held_pat));
        check_eq("hold_last", 32'(last), 32'(held_last));
      end
      stalled = 1'b0;
      check_eq("run_valid", 32'(pattern_valid), 32'd1);
      check_eq("run_busy", 32'(busy), 32'd1);
      if (pattern_valid && exp_q.size() != 0) begin
        if (out_ready) begin
          fin = exp_q[0].lst;
          check_handshake(k, hs);
          hs++;
        end else begin
          stalled   = 1'b1;
          held_pat  = pattern;
          held_last = last;
        end
      end
      tick();
      start = 1'b0;
    end
    check_eq("finished", 32'(fin), 32'd1);
    if (fin) begin
      check_eq("done_pulse", 32'(done), 32'd1);
      check_eq("done_busy", 32'(busy), 32'd0);
      check_eq("done_valid", 32'(pattern_valid), 32'd0);
      check_eq("idle_pattern", 32'(pattern), 32'd0);
      check_eq("idle_last", 32'(last), 32'd0);
      tick();
      check_eq("done_once", 32'(done), 32'd0);
    end
    check_eq("words_left", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pattern"}, 32'(pattern), 32'd0);
    check_eq({tag, "_valid"}, 32'(pattern_valid), 32'd0);
    check_eq({tag, "_last"}, 32'(last), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
`ifdef WPG_COUNT_EN
    check_eq({tag, "_idx"}, 32'(pattern_idx), 32'd0);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    weight    = 3'd0;
    out_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    run_seq(2, 1'b0, 1'b0);
    run_seq(3, 1'b1, 1'b0);
    run_seq(0, 1'b0, 1'b0);
    run_seq(6, 1'b0, 1'b0);

    // Out-of-range weight: error pulse only.
    start  = 1'b1;
    weight = 3'd7;
    tick();
    start = 1'b0;
    $display("weight=7: err=%b valid=%b busy=%b", err, pattern_valid, busy);
    check_eq("err_pulse", 32'(err), 32'd1);
    check_eq("err_valid", 32'(pattern_valid), 32'd0);
    check_eq("err_busy", 32'(busy), 32'd0);
    tick();
    check_eq("err_once", 32'(err), 32'd0);
    check_eq("err_still_idle", 32'(pattern_valid), 32'd0);

    // Reset after the fourth handshake of a weight=4 run.
    load_model(4);
    start  = 1'b1;
    weight = 3'd4;
    tick();
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("k4_valid", 32'(pattern_valid), 32'd1);
      check_handshake(4, i);
      tick();
    end
    rst_n     = 1'b0;
    out_ready = 1'b0;
    tick();
    check_all_zero("midreset");
    rst_n = 1'b1;
    run_seq(1, 1'b0, 1'b0);

    run_seq(2, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/weight_pattern_gen.md
WEIGHT_PATTERN_GEN -- requirements
Module: weight_pattern_gen

Interface
Parameters: none.
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have port start, input, 1 bit: one-cycle request to begin an enumeration.
REQ-004 The block SHALL have port weight, input, 3 bits: requested Hamming weight k, valid range 0..6, sampled when start is accepted.
REQ-005 The block SHALL have port out_ready, input, 1 bit: the consumer accepts pattern this cycle.
REQ-006 The block SHALL have port pattern, output, 6 bits: the current 6-bit word whose popcount equals k.
REQ-007 The block SHALL have port pattern_valid, output, 1 bit: pattern holds a valid word.
REQ-008 The block SHALL have port last, output, 1 bit: asserted with the final pattern of the enumeration.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an enumeration is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse on completion.
REQ-011 The block SHALL have port err, output, 1 bit: one-cycle pulse when start is accepted with weight = 7.

Function
REQ-012 The block SHALL emit every 6-bit word with exactly k ones, once each, in ascending numeric order; C(6,k) words in total.
REQ-013 The FSM SHALL have two states. IDLE moves to RUN on start=1 with weight<=6. RUN moves to IDLE on a handshake (pattern_valid & out_ready) while last=1.
REQ-014 On start accepted in IDLE, the block SHALL assert pattern_valid on the next cycle, with pattern = the lowest word of weight k, i.e. (1<<k)-1.
REQ-015 On each handshake with last=0, the block SHALL present the next-higher word of equal weight on the following cycle, keeping pattern_valid high: one word per cycle at full throughput, no bubbles.
REQ-016 While pattern_valid=1 and out_ready=0, pattern and last SHALL hold stable.
REQ-017 last SHALL be 1 exactly when pattern is the highest word of weight k, i.e. ((1<<k)-1)<<(6-k).
REQ-018 k=0 SHALL produce the single word 000000 with last=1. k=6 SHALL produce the single word 111111 with last=1.
REQ-019 done SHALL pulse high in the cycle after the final handshake, coincident with busy=0 and pattern_valid=0.
REQ-020 busy SHALL be high from the cycle after start is accepted through the cycle of the final handshake.
REQ-021 start SHALL be ignored while busy=1; the weight in progress is unaffected.
REQ-022 start with weight=7 in IDLE SHALL pulse err for one cycle on the next cycle, remain in IDLE, and emit no pattern.
REQ-023 In IDLE, pattern SHALL read 000000 and last SHALL read 0.
REQ-024 Sampling all handshaken words through a 6-bit popcount SHALL yield k for every word.

Reset
REQ-025 With rst_n=0 at a clock edge, the block SHALL enter IDLE and drive pattern=0, pattern_valid=0, last=0, busy=0, done=0, err=0 (pattern_idx=0 when WPG_COUNT_EN is defined).
REQ-026 Reset mid-enumeration SHALL abandon the sequence without a done pulse. A start in the first cycle after rst_n returns high SHALL be accepted normally.

Configuration
REQ-027 Macro WPG_COUNT_EN defined: the block SHALL add output pattern_idx, 5 bits, giving the 0-based ordinal of the current word within the enumeration (0..19). It SHALL be 0 on the first word, increment per handshake, and hold under backpressure.
REQ-028 Macro WPG_COUNT_EN undefined: pattern_idx and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 start, weight=2, out_ready=1 -> 15 consecutive words 03,05,06,09,0A,0C,11,12,14,18,21,22,24,28,30 (hex); last only on 30; done one cycle later.
REQ-030 start, weight=3, out_ready toggled pseudo-randomly -> 20 words from 07 to 38 (hex), each held stable while out_ready=0, no duplicates or skips; pattern_idx runs 0..19 when WPG_COUNT_EN is defined.
REQ-031 weight=0, then weight=6 -> single words 00 and 3F respectively, each with last=1, followed by done.
REQ-032 start, weight=7 -> err pulse on the next cycle, pattern_valid stays 0, busy stays 0.
REQ-033 rst_n=0 after the 4th handshake of a weight=4 run -> all outputs 0 on the next cycle, no done pulse; a new start with weight=1 -> 01,02,04,08,10,20 (hex).
REQ-034 start with weight=5 asserted during a weight=2 run -> ignored; the weight=2 sequence completes unchanged.
